// File: rtl/top_core.sv
// top_core: registered multi-function datapath (sum, xor accumulator, ALU, product, rotate, counter, parity).
// Optional macro TOP_PIPE_MUL_EN adds a second register stage on the product path.
module top_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [260:0] in_flat,
   output logic [329:0] out_flat
);

   function automatic logic parity_261(input logic [260:0] v);
      return ^v;
   endfunction

   logic [63:0]  a_s;
   logic [63:0]  b_s;
   logic [63:0]  c_s;
   logic [31:0]  d_s;
   logic [31:0]  e_s;
   logic [4:0]   op_s;

   logic [64:0]  sum_s;
   logic [63:0]  alu_raw_s;
   logic [63:0]  alu_s;
   logic [63:0]  prod_s;
   logic [127:0] rot_dbl_s;
   logic [63:0]  rot_s;

   logic [64:0]  sum_r;
   logic [63:0]  acc_r;
   logic [63:0]  alu_r;
   logic [63:0]  prod_r;
   logic [63:0]  rot_r;
   logic [7:0]   cnt_r;
   logic         par_r;

   assign a_s  = in_flat[63:0];
   assign b_s  = in_flat[127:64];
   assign c_s  = in_flat[191:128];
   assign d_s  = in_flat[223:192];
   assign e_s  = in_flat[255:224];
   assign op_s = in_flat[260:256];

   assign sum_s  = {1'b0, a_s} + {1'b0, b_s};
   assign prod_s = {32'd0, d_s} * {32'd0, e_s};

   // Upper half of the doubled word shifted left is C rotated left by OP[4:0].
   assign rot_dbl_s = {c_s, c_s} << op_s;
   assign rot_s     = rot_dbl_s[127:64];

   // ALU function select with optional bitwise inversion from OP[3].
   always_comb begin
      alu_raw_s = 64'd0;
      alu_s     = 64'd0;
      case (op_s[2:0])
         3'd0:    alu_raw_s = a_s + b_s;
         3'd1:    alu_raw_s = a_s - b_s;
         3'd2:    alu_raw_s = a_s & b_s;
         3'd3:    alu_raw_s = a_s | b_s;
         3'd4:    alu_raw_s = a_s ^ b_s;
         3'd5:    alu_raw_s = a_s << b_s[5:0];
         3'd6:    alu_raw_s = a_s >> b_s[5:0];
         3'd7:    alu_raw_s = {63'd0, (a_s < b_s)};
         default: alu_raw_s = 64'd0;
      endcase
      if (op_s[3]) begin
         alu_s = ~alu_raw_s;
      end else begin
         alu_s = alu_raw_s;
      end
   end

   // Result registers for every field except the product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r <= 65'd0;
         acc_r <= 64'd0;
         alu_r <= 64'd0;
         rot_r <= 64'd0;
         cnt_r <= 8'd0;
         par_r <= 1'b0;
      end else begin
         sum_r <= sum_s;
         acc_r <= acc_r ^ c_s;
         alu_r <= alu_s;
         rot_r <= rot_s;
         cnt_r <= cnt_r + 8'd1;
         par_r <= parity_261(in_flat);
      end
   end

`ifdef TOP_PIPE_MUL_EN
   logic [63:0] prod_stage_r;

   // Two-stage product path; the intermediate stage also clears on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_stage_r <= 64'd0;
         prod_r       <= 64'd0;
      end else begin
         prod_stage_r <= prod_s;
         prod_r       <= prod_stage_r;
      end
   end
`else
   // Single-stage product register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_r <= 64'd0;
      end else begin
         prod_r <= prod_s;
      end
   end
`endif

   assign out_flat = {par_r, cnt_r, rot_r, prod_r, alu_r, acc_r, sum_r};

endmodule

// File: tb/tb_top_core.sv
// Scoreboard bench for top_core: directed vectors push expected fields, a monitor pops and compares.
// Honours TOP_PIPE_MUL_EN for the product latency.
module tb_top_core;

   logic         clk;
   logic         rst_n;
   logic [260:0] in_flat;
   logic [329:0] out_flat;

   top_core dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_flat  (in_flat),
      .out_flat (out_flat)
   );

`ifdef TOP_PIPE_MUL_EN
   localparam int PROD_LAT = 2;
`else
   localparam int PROD_LAT = 1;
`endif

   localparam int SUM_LO  = 0;
   localparam int ACC_LO  = 65;
   localparam int ALU_LO  = 129;
   localparam int PROD_LO = 193;
   localparam int ROT_LO  = 257;
   localparam int CNT_LO  = 321;
   localparam int PAR_LO  = 329;

   typedef struct {
      int          due;
      int          lo;
      int          width;
      logic [64:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   edge_n   = 0;
   int   next_due = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one sample per rising edge; compares every expectation that falls due on this edge.
   always @(posedge clk) begin : monitor
      logic [329:0] sh;
      logic [64:0]  got;
      logic [64:0]  m;
      int           idx;
      #1;
      if (!rst_n) begin
         edge_n = 0;
      end else begin
         edge_n = edge_n + 1;
         idx = 0;
         while (idx < sb.size()) begin
            if (sb[idx].due <= edge_n) begin
               sh  = out_flat >> sb[idx].lo;
               m   = (sb[idx].width >= 65) ? {65{1'b1}} : ((65'd1 << sb[idx].width) - 65'd1);
               got = sh[64:0] & m;
               n_checks++;
               if (sb[idx].due < edge_n) begin
                  n_fail++;
                  $display("FAIL %s: stale entry due edge %0d seen at edge %0d", sb[idx].name, sb[idx].due, edge_n);
               end else if (got !== sb[idx].val) begin
                  n_fail++;
                  $display("FAIL %s @edge %0d: got %h expected %h", sb[idx].name, edge_n, got, sb[idx].val);
               end
               sb.delete(idx);
            end else begin
               idx++;
            end
         end
      end
   end

   task automatic set_ops(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          input logic [31:0] d, input logic [31:0] e, input logic [4:0] op);
      in_flat  = {op, e, d, c, b, a};
      next_due = edge_n + 1;
   endtask

   task automatic set_raw(input logic [260:0] v);
      in_flat  = v;
      next_due = edge_n + 1;
   endtask

   task automatic expect_f(input string name, input int due, input int lo, input int width, input logic [64:0] val);
      exp_t e;
      e.due   = due;
      e.lo    = lo;
      e.width = width;
      e.val   = val;
      e.name  = name;
      sb.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if (out_flat !== 330'd0) begin
         n_fail++;
         $display("FAIL %s: got %h required 0", name, out_flat);
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst_n   = 1'b0;
      in_flat = 261'd0;

      // Reset held low with random operands: outputs must stay clear.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_flat = 261'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                         $urandom(), $urandom(), $urandom(), $urandom()});
      end
      @(negedge clk);
      check_zero("reset_hold");
      rst_n = 1'b1;

      // Carry-out sum and full-scale product.
      set_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      expect_f("sum_carry", next_due, SUM_LO, 65, 65'h1_FFFF_FFFF_FFFF_FFFE);
      expect_f("cnt_first", next_due, CNT_LO, 8, 65'd1);
      expect_f("acc_zero",  next_due, ACC_LO, 64, 65'd0);
      expect_f("alu_add",   next_due, ALU_LO, 64, 65'hFFFF_FFFF_FFFF_FFFE);
      expect_f("par_even",  next_due, PAR_LO, 1, 65'd0);
      expect_f("prod_max",  next_due + PROD_LAT - 1, PROD_LO, 64, 65'hFFFF_FFFE_0000_0001);
      step();

      set_ops(64'd1, 64'd2, 64'd0, 32'd3, 32'd5, 5'd7);
      expect_f("alu_lt",    next_due, ALU_LO, 64, 65'd1);
      expect_f("cnt_second", next_due, CNT_LO, 8, 65'd2);
      expect_f("sum_small", next_due, SUM_LO, 65, 65'd3);
      expect_f("par_odd",   next_due, PAR_LO, 1, 65'd1);
      expect_f("prod_small", next_due + PROD_LAT - 1, PROD_LO, 64, 65'd15);
      step();

      set_ops(64'd1, 64'd2, 64'd0, 32'd0, 32'd0, 5'd15);
      expect_f("alu_lt_inv", next_due, ALU_LO, 64, 65'hFFFF_FFFF_FFFF_FFFE);
      expect_f("par_op15",   next_due, PAR_LO, 1, 65'd0);
      step();

      set_ops(64'd1, 64'd63, 64'd0, 32'd0, 32'd0, 5'd5);
      expect_f("alu_shl63", next_due, ALU_LO, 64, 65'h8000_0000_0000_0000);
      step();

      set_ops(64'd0, 64'd1, 64'd0, 32'd0, 32'd0, 5'd1);
      expect_f("alu_sub_wrap", next_due, ALU_LO, 64, 65'hFFFF_FFFF_FFFF_FFFF);
      expect_f("sum_01",       next_due, SUM_LO, 65, 65'd1);
      step();

      set_ops(64'h8000_0000_0000_0000, 64'd63, 64'd0, 32'd0, 32'd0, 5'd6);
      expect_f("alu_shr63", next_due, ALU_LO, 64, 65'd1);
      step();

      set_ops(64'hF0, 64'hFF, 64'd0, 32'd0, 32'd0, 5'd4);
      expect_f("alu_xor", next_due, ALU_LO, 64, 65'h0F);
      step();

      set_ops(64'hFF00, 64'h0FF0, 64'd0, 32'd0, 32'd0, 5'd18);
      expect_f("alu_and_op4", next_due, ALU_LO, 64, 65'h0F00);
      step();

      set_raw(261'h1);
      expect_f("par_one", next_due, PAR_LO, 1, 65'd1);
      expect_f("alu_raw1", next_due, ALU_LO, 64, 65'd1);
      step();

      set_raw(261'h3);
      expect_f("par_two", next_due, PAR_LO, 1, 65'd0);
      expect_f("sum_raw3", next_due, SUM_LO, 65, 65'd3);
      step();
      drain();

      // Asynchronous reset mid-operation clears outputs without a clock edge.
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      step();
      step();
      check_zero("reset_mid_hold");
      rst_n = 1'b1;

      // Accumulator restarts from zero after reset.
      for (int k = 0; k < 3; k++) begin
         set_ops(64'd0, 64'd0, 64'h0F0F_0F0F_0F0F_0F0F, 32'd0, 32'd0, 5'd0);
         expect_f("acc_seq", next_due, ACC_LO, 64, (k == 1) ? 65'd0 : 65'h0F0F_0F0F_0F0F_0F0F);
         expect_f("cnt_restart", next_due, CNT_LO, 8, 65'(k + 1));
         step();
      end

      set_ops(64'd0, 64'd0, 64'h8000_0000_0000_0001, 32'd0, 32'd0, 5'd1);
      expect_f("rot_by1",  next_due, ROT_LO, 64, 65'h0000_0000_0000_0003);
      expect_f("acc_mix1", next_due, ACC_LO, 64, 65'h8F0F_0F0F_0F0F_0F0E);
      step();

      set_ops(64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, 32'd0, 32'd0, 5'd0);
      expect_f("rot_by0",  next_due, ROT_LO, 64, 65'h1234_5678_9ABC_DEF0);
      expect_f("acc_mix2", next_due, ACC_LO, 64, 65'h9D3B_5977_95B3_D1FE);
      step();

      set_ops(64'd0, 64'd0, 64'd1, 32'd0, 32'd0, 5'd31);
      expect_f("rot_by31",   next_due, ROT_LO, 64, 65'h0000_0000_8000_0000);
      expect_f("alu_inv_ge", next_due, ALU_LO, 64, 65'hFFFF_FFFF_FFFF_FFFF);
      step();

      // Run the counter through its wrap point.
      while (edge_n + 1 <= 256) begin
         set_ops(64'd0, 64'd0, 64'd0, 32'd0, 32'd0, 5'd0);
         if (next_due == 255) expect_f("cnt_255", next_due, CNT_LO, 8, 65'd255);
         if (next_due == 256) expect_f("cnt_wrap", next_due, CNT_LO, 8, 65'd0);
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
